// File: rtl/ex_muldiv_ctrl_if.sv
// Request/result bundle between the EX stage and the iterative multiply/divide
// sequencer. The pipeline side is the master; the sequencer is the slave.
interface ex_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Op;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic             Flush;
  logic             Stall;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, OpA, OpB, Flush,
    input  Stall, Busy, Done, DivByZero, Hi, Lo
  );

  modport slave (
    input  Start, Op, OpA, OpB, Flush,
    output Stall, Busy, Done, DivByZero, Hi, Lo
  );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Iterative unsigned MULTU/DIVU sequencer for the execute stage.
// One shared 2*WIDTH-bit working register is shifted once per cycle: right
// with a shift-add for MULTU, left with a restoring subtract for DIVU.
// HI/LO are written on the edge that finishes the last iteration; a divide by
// zero skips the iterations and reports straight away.
module ex_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input logic              CLK,
  input logic              RST,
  ex_muldiv_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One shift-add iteration: {carry, acc, mplr} >> 1 after an optional add.
  function automatic logic [2*WIDTH-1:0] mulStep(
    input logic [2*WIDTH-1:0] work,
    input logic [WIDTH-1:0]   mcand
  );
    logic [WIDTH:0] sum;
    if (work[0]) begin
      sum = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    end else begin
      sum = {1'b0, work[2*WIDTH-1:WIDTH]};
    end
    return {sum, work[WIDTH-1:1]};
  endfunction

  // One restoring-division iteration. The remainder is always below the
  // divisor, so after the left shift it fits in WIDTH+1 bits and the sign of
  // the WIDTH+1-bit trial difference is exact.
  function automatic logic [2*WIDTH-1:0] divStep(
    input logic [2*WIDTH-1:0] work,
    input logic [WIDTH-1:0]   dvsr
  );
    logic [WIDTH:0] remExt;
    logic [WIDTH:0] trial;
    remExt = work[2*WIDTH-1:WIDTH-1];
    trial  = remExt - {1'b0, dvsr};
    if (!trial[WIDTH]) begin
      return {trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
    end else begin
      return {remExt[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
    end
  endfunction

  state_t             state_r;
  state_t             stateNext_s;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] work_r;
  logic [WIDTH-1:0]   opB_r;
  logic               op_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;
  logic               divByZero_r;

  logic               accept_s;
  logic               divZeroReq_s;
  logic               lastIter_s;
  logic [2*WIDTH-1:0] stepWork_s;

  assign accept_s     = (state_r == IDLE) && bus.Start && !bus.Flush;
  assign divZeroReq_s = bus.Op && (bus.OpB == {WIDTH{1'b0}});
  assign lastIter_s   = (cnt_r == CW'(WIDTH - 1));

  // Shared datapath: pick the iteration for the latched operation.
  always_comb begin
    stepWork_s = work_r;
    if (op_r) begin
      stepWork_s = divStep(work_r, opB_r);
    end else begin
      stepWork_s = mulStep(work_r, opB_r);
    end
  end

  // Next-state logic of the IDLE/RUN/DONE sequencer.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (divZeroReq_s) begin
            stateNext_s = DONE;
          end else begin
            stateNext_s = RUN;
          end
        end else begin
          stateNext_s = IDLE;
        end
      end
      RUN: begin
        if (bus.Flush) begin
          stateNext_s = IDLE;
        end else if (lastIter_s) begin
          stateNext_s = DONE;
        end else begin
          stateNext_s = RUN;
        end
      end
      DONE:    stateNext_s = IDLE;
      default: stateNext_s = IDLE;
    endcase
  end

  // State register plus registered Busy/Done/DivByZero decodes of the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      divByZero_r <= 1'b0;
    end else begin
      state_r     <= stateNext_s;
      busy_r      <= (stateNext_s == RUN);
      done_r      <= (stateNext_s == DONE);
      divByZero_r <= accept_s && divZeroReq_s;
    end
  end

  // Operand capture, iteration and HI/LO write-back.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r  <= {CW{1'b0}};
      work_r <= {(2*WIDTH){1'b0}};
      opB_r  <= {WIDTH{1'b0}};
      op_r   <= 1'b0;
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r   <= bus.Op;
            opB_r  <= bus.OpB;
            work_r <= {{WIDTH{1'b0}}, bus.OpA};
            cnt_r  <= {CW{1'b0}};
            if (divZeroReq_s) begin
              hi_r <= bus.OpA;
              lo_r <= {WIDTH{1'b1}};
            end else begin
              hi_r <= hi_r;
              lo_r <= lo_r;
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        RUN: begin
          if (!bus.Flush) begin
            work_r <= stepWork_s;
            cnt_r  <= cnt_r + CW'(1);
            if (lastIter_s) begin
              hi_r <= stepWork_s[2*WIDTH-1:WIDTH];
              lo_r <= stepWork_s[WIDTH-1:0];
            end else begin
              hi_r <= hi_r;
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Stall must reach the pipeline in the accepting cycle, so it stays combinational.
  assign bus.Stall     = accept_s || (state_r == RUN);
  assign bus.Busy      = busy_r;
  assign bus.Done      = done_r;
  assign bus.DivByZero = divByZero_r;
  assign bus.Hi        = hi_r;
  assign bus.Lo        = lo_r;

endmodule
